imem_loader: RTL and testbench

- Host-side loader that writes a program image into instruction memory before the processor runs.
- Accepts a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit words and drives the imem write port starting at address 0.
- Holds the processor in reset for the whole load, then releases it.
- It is the writer end of the imem interface; the processor only ever reads that memory.

---
 rtl/imem_loader_if.sv | 23 ++
 rtl/imem_loader.sv | 131 +++++++++++++
 tb/tb_imem_loader.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write port of the program loader.
// master = host side of the stream; slave = the loader, which also drives the imem write port.
interface imem_loader_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] imem_address;
  logic [DATA_W-1:0] imem_data;
  logic              imem_wren;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_address, imem_data, imem_wren
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_address, imem_data, imem_wren
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a framed, checksummed byte stream into instruction memory as big-endian words,
// holding the processor in reset until the load has finished successfully.
module imem_loader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_reset,
  output logic         done,
  output logic         error
);
  localparam int LEN_W = 12;

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHECK, DONE, ERR
  } state_t;

  state_t           state, state_next;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] word_idx;
  logic [1:0]       byte_idx;
  logic [23:0]      word_q;     // first three bytes of the word being assembled
  logic [7:0]       checksum;
  logic             ready;
  logic             accept;
  logic             last_word;

  assign accept       = bus.in_valid & ready;
  assign last_word    = (word_idx + LEN_W'(1)) == len_q;
  assign bus.in_ready = ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    cpu_reset  = reset || !(state inside {IDLE, DONE});
    unique case (state)
      IDLE, DONE, ERR: if (start) state_next = LEN_HI;
      LEN_HI: begin
        ready = 1'b1;
        if (bus.in_valid) state_next = (bus.in_data[7:4] != 4'd0) ? ERR : LEN_LO;
      end
      LEN_LO: begin
        ready = 1'b1;
        if (bus.in_valid)
          state_next = ({len_q[11:8], bus.in_data} == LEN_W'(0)) ? CHECK : DATA;
      end
      DATA: begin
        ready = 1'b1;
        if (bus.in_valid && byte_idx == 2'd3) state_next = WRITE;
      end
      WRITE: state_next = last_word ? CHECK : DATA;
      CHECK: begin
        ready = 1'b1;
        if (bus.in_valid) state_next = (bus.in_data == checksum) ? DONE : ERR;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      len_q            <= '0;
      word_idx         <= '0;
      byte_idx         <= '0;
      word_q           <= '0;
      checksum         <= '0;
      bus.imem_address <= '0;
      bus.imem_data    <= '0;
      bus.imem_wren    <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            done             <= 1'b0;
            error            <= 1'b0;
            checksum         <= '0;
            word_idx         <= '0;
            bus.imem_address <= '0;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len_q[11:8] <= bus.in_data[3:0];
            if (bus.in_data[7:4] != 4'd0) error <= 1'b1;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len_q[7:0] <= bus.in_data;
            byte_idx   <= '0;
          end
        end
        DATA: begin
          if (accept) begin
            word_q   <= {word_q[15:0], bus.in_data};
            checksum <= checksum ^ bus.in_data;
            byte_idx <= byte_idx + 2'd1;
            // Register the write here so wren is high in the cycle right after the 4th byte.
            if (byte_idx == 2'd3) begin
              bus.imem_wren    <= 1'b1;
              bus.imem_data    <= DATA_W'({word_q, bus.in_data});
              bus.imem_address <= ADDR_W'(word_idx);
            end
          end
        end
        WRITE: begin
          bus.imem_wren <= 1'b0;
          word_idx      <= word_idx + LEN_W'(1);
        end
        CHECK: begin
          if (accept) begin
            if (bus.in_data == checksum) done  <= 1'b1;
            else                         error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Randomised scoreboard bench for imem_loader: a frame-level model predicts writes and outcome,
// a monitor checks every imem write as it appears.
module tb_imem_loader;
  typedef logic [7:0] bytes_t[$];
  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic cpu_reset, done, error;
  int   total = 0;
  int   bad   = 0;
  bit   stall_en = 1'b0;
  wr_t  exp_q[$];

  imem_loader_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  imem_loader #(.ADDR_W(12), .DATA_W(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .cpu_reset(cpu_reset),
    .done     (done),
    .error    (error)
  );

  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write the DUT issues must match the oldest predicted write.
  always @(negedge clock) begin
    wr_t e;
    if (!reset && bus.imem_wren) begin
      check("ready_in_write", 64'(bus.in_ready), 64'(0));
      if (exp_q.size() == 0) begin
        check("unexpected_wr", 64'(bus.imem_address), 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(bus.imem_address), 64'(e.addr));
        check("wr_data", 64'(bus.imem_data), 64'(e.data));
      end
    end
  end

  // Reference model: interprets the whole frame from the format rules.
  task automatic model_frame(input bytes_t fr, output bit exp_done, output bit exp_err);
    int          n;
    logic [7:0]  cs;
    logic [31:0] w;
    exp_done = 1'b0;
    exp_err  = 1'b1;
    if (fr[0] > 8'h0F) return;
    n  = int'(fr[0]) * 256 + int'(fr[1]);
    cs = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = 32'h0;
      for (int k = 0; k < 4; k++) begin
        w  = w * 256 + 32'(fr[2 + 4*i + k]);
        cs = cs ^ fr[2 + 4*i + k];
      end
      exp_q.push_back('{addr: 12'(i), data: w});
    end
    exp_done = (fr[2 + 4*n] == cs);
    exp_err  = !exp_done;
  endtask

  task automatic make_frame(input int n, input bit corrupt, output bytes_t fr);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    fr = {};
    fr.push_back(8'(n >> 8));
    fr.push_back(8'(n & 255));
    for (int i = 0; i < 4*n; i++) begin
      b = 8'($urandom);
      fr.push_back(b);
      cs = cs ^ b;
    end
    if (corrupt) cs = cs ^ 8'($urandom_range(1, 255));
    fr.push_back(cs);
  endtask

  task automatic pulse_start();
    bus.in_valid = 1'b0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    if (stall_en) begin
      repeat ($urandom_range(0, 3)) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        @(posedge clock); #1;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    guard = 0;
    @(negedge clock);
    while (!bus.in_ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (!bus.in_ready) begin
      check("byte_accept_timeout", 64'(0), 64'(1));
      bus.in_valid = 1'b0;
      return;
    end
    check("cpu_reset_load", 64'(cpu_reset), 64'(1));
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  task automatic wait_outcome(input bit exp_done, input bit exp_err);
    int guard = 0;
    @(negedge clock);
    while (!(done || error) && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    if (!(done || error)) check("outcome_timeout", 64'(0), 64'(1));
    check("done", 64'(done), 64'(exp_done));
    check("error", 64'(error), 64'(exp_err));
    check("cpu_reset_after", 64'(cpu_reset), 64'(!exp_done));
    check("pending_writes", 64'(exp_q.size()), 64'(0));
    @(posedge clock); #1;
  endtask

  // pulse_at >= 0 pulses start just before that byte, while the loader is mid-frame.
  task automatic send_frame(input bytes_t fr, input int pulse_at);
    bit ed, ee;
    int words;
    model_frame(fr, ed, ee);
    pulse_start();
    for (int i = 0; i < fr.size(); i++) begin
      if (i == pulse_at) begin
        words = (pulse_at - 2) / 4;
        pulse_start();
        check("addr_hold", 64'(bus.imem_address), 64'(words > 0 ? words - 1 : 0));
      end
      send_byte(fr[i]);
    end
    wait_outcome(ed, ee);
  endtask

  initial begin
    bytes_t fr;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("cpu_reset_in_reset", 64'(cpu_reset), 64'(1));
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("idle_cpu_reset", 64'(cpu_reset), 64'(0));
    check("idle_in_ready", 64'(bus.in_ready), 64'(0));
    check("idle_wren", 64'(bus.imem_wren), 64'(0));
    check("idle_done", 64'(done), 64'(0));
    check("idle_error", 64'(error), 64'(0));
    check("idle_addr", 64'(bus.imem_address), 64'(0));
    check("idle_data", 64'(bus.imem_data), 64'(0));
    @(posedge clock); #1;

    // Two known words; 0x00 is the XOR of the eight data bytes, 0x89 is wrong.
    fr = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};
    send_frame(fr, -1);
    fr[10] = 8'h89;
    send_frame(fr, -1);
    fr[10] = 8'h00;
    send_frame(fr, -1);

    // Length high nibble set: error after one byte. Then an empty program.
    fr = '{8'h10};
    send_frame(fr, -1);
    fr = '{8'h00, 8'h00, 8'h00};
    send_frame(fr, -1);

    // Back-pressured 3-word load.
    stall_en = 1'b1;
    make_frame(3, 1'b0, fr);
    send_frame(fr, -1);

    // Reset mid-load after two data bytes of the first word.
    stall_en = 1'b0;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    reset = 1'b1;
    @(negedge clock);
    check("abort_cpu_reset", 64'(cpu_reset), 64'(1));
    check("abort_in_ready", 64'(bus.in_ready), 64'(0));
    check("abort_wren", 64'(bus.imem_wren), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("abort_idle_cpu_reset", 64'(cpu_reset), 64'(0));
    check("abort_pending", 64'(exp_q.size()), 64'(0));
    @(posedge clock); #1;

    // start pulsed in the middle of the third word must be ignored.
    make_frame(3, 1'b0, fr);
    send_frame(fr, 12);

    // Word count using the high length byte.
    make_frame(256, 1'b0, fr);
    send_frame(fr, -1);

    // Random frames, some with corrupted checksums, under back-pressure.
    stall_en = 1'b1;
    for (int t = 0; t < 8; t++) begin
      make_frame($urandom_range(1, 5), ($urandom_range(0, 2) == 0), fr);
      send_frame(fr, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
